// File: rtl/cache_plru_unit.sv
// cache_plru_unit
//   Per-set 4-way tree pseudo-LRU store. A lookup in stage 1 returns, one
//   cycle later, the 3 PLRU bits of the held set and the way to evict.
//   Hits and fills from stage 2 update the array every cycle. An update to
//   the set being read is forwarded, so back-to-back accesses see fresh bits.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   rd_en_i      lookup request (sampled when stall_i=0)
//   rd_set_i     set index of the lookup
//   stall_i      pipeline stall, holds the output stage
//   upd_en_i     access update (hit or fill completion)
//   upd_set_i    set being updated
//   upd_way_i    accessed way: 0=A 1=B 2=C 3=D
//   way_valid_i  valid bits of the looked-up set (output cycle)
//   lru_valid_o  lru_out_o / victim_way_o are meaningful
//   lru_out_o    PLRU bits of the held set
//   victim_way_o way to evict for the held set
//
// PLRU encoding: bit2 = root (0 -> A/B pair is LRU, 1 -> C/D pair is LRU),
// bit1 = LRU within A/B (0=A), bit0 = LRU within C/D (0=C).

module cache_plru_unit #(
  parameter int NUM_SETS = 16,
  parameter int SET_W    = 4,
  parameter int LRU_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en_i,
  input  logic [SET_W-1:0] rd_set_i,
  input  logic             stall_i,
  input  logic             upd_en_i,
  input  logic [SET_W-1:0] upd_set_i,
  input  logic [1:0]       upd_way_i,
  input  logic [3:0]       way_valid_i,
  output logic             lru_valid_o,
  output logic [LRU_W-1:0] lru_out_o,
  output logic [1:0]       victim_way_o
);

  logic [LRU_W-1:0] lru_q [NUM_SETS];

  logic [SET_W-1:0] held_set_q, held_set_d;
  logic             lru_valid_q, lru_valid_d;
  logic [LRU_W-1:0] lru_out_q, lru_out_d;

  logic [LRU_W-1:0] upd_bits;
  logic [LRU_W-1:0] rd_bits;

  // Point the touched path away from the accessed way; the bit of the
  // opposite pair is left as it was.
  function automatic logic [LRU_W-1:0] touch(input logic [LRU_W-1:0] cur,
                                             input logic [1:0]       way);
    logic [LRU_W-1:0] nxt;
    nxt = cur;
    case (way)
      2'd0:    begin nxt[2] = 1'b1; nxt[1] = 1'b1; end
      2'd1:    begin nxt[2] = 1'b1; nxt[1] = 1'b0; end
      2'd2:    begin nxt[2] = 1'b0; nxt[0] = 1'b1; end
      default: begin nxt[2] = 1'b0; nxt[0] = 1'b0; end
    endcase
    return nxt;
  endfunction

  assign upd_bits = touch(lru_q[upd_set_i], upd_way_i);

  // Read port sees the value the array will hold after this edge.
  assign rd_bits = (upd_en_i && (upd_set_i == rd_set_i)) ? upd_bits
                                                         : lru_q[rd_set_i];

  // PLRU array: updates commit regardless of stall or lookup activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        lru_q[i] <= '0;
      end
    end else if (upd_en_i) begin
      lru_q[upd_set_i] <= upd_bits;
    end
  end

  // Output stage next state. While stalled only a refresh of the held set
  // is allowed so the stage-2 consumer never sees stale bits.
  always_comb begin
    held_set_d  = held_set_q;
    lru_valid_d = lru_valid_q;
    lru_out_d   = lru_out_q;
    if (!stall_i) begin
      held_set_d  = rd_set_i;
      lru_valid_d = rd_en_i;
      lru_out_d   = rd_bits;
    end else if (upd_en_i && (upd_set_i == held_set_q)) begin
      lru_out_d = upd_bits;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_set_q  <= '0;
      lru_valid_q <= 1'b0;
      lru_out_q   <= '0;
    end else begin
      held_set_q  <= held_set_d;
      lru_valid_q <= lru_valid_d;
      lru_out_q   <= lru_out_d;
    end
  end

  // Invalid ways are filled first (lowest index wins); otherwise follow
  // the tree to the LRU leaf.
  always_comb begin
    victim_way_o = 2'd0;
    if (!way_valid_i[0]) begin
      victim_way_o = 2'd0;
    end else if (!way_valid_i[1]) begin
      victim_way_o = 2'd1;
    end else if (!way_valid_i[2]) begin
      victim_way_o = 2'd2;
    end else if (!way_valid_i[3]) begin
      victim_way_o = 2'd3;
    end else if (!lru_out_q[2]) begin
      victim_way_o = {1'b0, lru_out_q[1]};
    end else begin
      victim_way_o = {1'b1, lru_out_q[0]};
    end
  end

  assign lru_valid_o = lru_valid_q;
  assign lru_out_o   = lru_out_q;

endmodule

// File: tb/tb_cache_plru_unit.sv
// tb_cache_plru_unit
//   Directed vector table for the documented corner cases, a mid-cycle
//   asynchronous reset sequence, then randomized traffic compared against a
//   behavioural tree-PLRU model of all sets.

module tb_cache_plru_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdEn;
  logic [3:0] rdSet;
  logic       stall;
  logic       updEn;
  logic [3:0] updSet;
  logic [1:0] updWay;
  logic [3:0] wayValid;
  logic       lruValid;
  logic [2:0] lruOut;
  logic [1:0] victimWay;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_plru_unit #(.NUM_SETS(16), .SET_W(4), .LRU_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_en_i      (rdEn),
    .rd_set_i     (rdSet),
    .stall_i      (stall),
    .upd_en_i     (updEn),
    .upd_set_i    (updSet),
    .upd_way_i    (updWay),
    .way_valid_i  (wayValid),
    .lru_valid_o  (lruValid),
    .lru_out_o    (lruOut),
    .victim_way_o (victimWay)
  );

  // Reference model: per-set tree bits plus the output stage contents.
  bit [2:0] mArr [16];
  bit [3:0] mHeld;
  bit       mValid;
  bit [2:0] mOut;

  // An access makes the root point at the other pair, and the pair's own
  // bit point at the sibling of the accessed way.
  function automatic bit [2:0] refTouch(bit [2:0] p, int way);
    bit [2:0] r;
    r = p;
    if (way < 2) begin
      r[2] = 1'b1;
      r[1] = (way == 0);
    end else begin
      r[2] = 1'b0;
      r[0] = (way == 2);
    end
    return r;
  endfunction

  function automatic bit [1:0] refVictim(bit [2:0] p, bit [3:0] wv);
    for (int i = 0; i < 4; i++) begin
      if (!wv[i]) return 2'(i);
    end
    if (p[2] == 1'b0) return p[1] ? 2'd1 : 2'd0;
    return p[0] ? 2'd3 : 2'd2;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mArr[i] = 3'b000;
    mHeld  = 4'd0;
    mValid = 1'b0;
    mOut   = 3'b000;
  endtask

  task automatic modelEdge();
    bit [2:0] newArr [16];
    newArr = mArr;
    if (updEn) newArr[updSet] = refTouch(mArr[updSet], int'(updWay));
    if (!stall) begin
      mHeld  = rdSet;
      mValid = rdEn;
      mOut   = newArr[rdSet];
    end else if (updEn && updSet == mHeld) begin
      mOut = newArr[mHeld];
    end
    mArr = newArr;
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, and
  // leave the caller 1 time unit after the next rising edge.
  task automatic applyStimulus(input bit e, input bit [3:0] s, input bit st,
                               input bit ue, input bit [3:0] us,
                               input bit [1:0] uw, input bit [3:0] wv);
    @(negedge clk);
    rdEn = e; rdSet = s; stall = st;
    updEn = ue; updSet = us; updWay = uw; wayValid = wv;
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int idx, input bit expValid,
                             input bit [2:0] expOut, input bit [1:0] expVictim);
    checks++;
    if (lruValid !== expValid) begin
      errors++;
      $display("[TB] FAIL %s[%0d] lru_valid got=%0b want=%0b", tag, idx, lruValid, expValid);
    end
    checks++;
    if (lruOut !== expOut) begin
      errors++;
      $display("[TB] FAIL %s[%0d] lru_out got=%03b want=%03b", tag, idx, lruOut, expOut);
    end
    checks++;
    if (victimWay !== expVictim) begin
      errors++;
      $display("[TB] FAIL %s[%0d] victim_way got=%0d want=%0d", tag, idx, victimWay, expVictim);
    end
  endtask

  typedef struct {
    bit       rdEn;
    bit [3:0] rdSet;
    bit       stall;
    bit       updEn;
    bit [3:0] updSet;
    bit [1:0] updWay;
    bit [3:0] wayValid;
    bit       expValid;
    bit [2:0] expOut;
    bit [1:0] expVictim;
  } vec_t;

  function automatic vec_t mk(bit e, bit [3:0] s, bit st, bit ue, bit [3:0] us,
                              bit [1:0] uw, bit [3:0] wv, bit xv, bit [2:0] xo,
                              bit [1:0] xw);
    vec_t v;
    v.rdEn = e; v.rdSet = s; v.stall = st; v.updEn = ue; v.updSet = us;
    v.updWay = uw; v.wayValid = wv; v.expValid = xv; v.expOut = xo;
    v.expVictim = xw;
    return v;
  endfunction

  vec_t vecs [19];

  initial begin
    // Expected values follow the tree rules directly:
    // A -> 11x, C -> 0x1, B -> 10x, D -> 0x0 (x = untouched bit).
    vecs[0]  = mk(1, 5, 0, 0, 0, 0, 4'b1111, 1, 3'b000, 0);  // first lookup
    vecs[1]  = mk(0, 0, 0, 1, 5, 0, 4'b1111, 0, 3'b000, 0);  // set5: 110
    vecs[2]  = mk(0, 0, 0, 1, 5, 2, 4'b1111, 0, 3'b000, 0);  // set5: 011
    vecs[3]  = mk(0, 0, 0, 1, 5, 1, 4'b1111, 0, 3'b000, 0);  // set5: 101
    vecs[4]  = mk(0, 0, 0, 1, 5, 3, 4'b1111, 0, 3'b000, 0);  // set5: 000
    vecs[5]  = mk(1, 5, 0, 0, 0, 0, 4'b1111, 1, 3'b000, 0);  // victim A
    vecs[6]  = mk(0, 0, 0, 1, 5, 0, 4'b1111, 0, 3'b000, 0);  // set5: 110
    vecs[7]  = mk(1, 5, 0, 0, 0, 0, 4'b1111, 1, 3'b110, 2);  // victim C
    vecs[8]  = mk(1, 3, 0, 1, 3, 2, 4'b1111, 1, 3'b001, 0);  // forwarding
    vecs[9]  = mk(1, 5, 0, 0, 0, 0, 4'b1111, 1, 3'b110, 2);
    vecs[10] = mk(1, 1, 1, 0, 0, 0, 4'b1011, 1, 3'b110, 2);  // C invalid
    vecs[11] = mk(0, 1, 1, 0, 0, 0, 4'b1101, 1, 3'b110, 1);  // B invalid
    vecs[12] = mk(0, 1, 1, 0, 0, 0, 4'b1111, 1, 3'b110, 2);  // PLRU pick
    vecs[13] = mk(0, 0, 1, 0, 0, 0, 4'b0110, 1, 3'b110, 0);  // A and D invalid
    vecs[14] = mk(1, 7, 0, 0, 0, 0, 4'b1111, 1, 3'b000, 0);  // read set 7
    vecs[15] = mk(0, 2, 1, 1, 9, 0, 4'b1111, 1, 3'b000, 0);  // other set updated
    vecs[16] = mk(0, 2, 1, 1, 7, 1, 4'b1111, 1, 3'b100, 2);  // held set refresh
    vecs[17] = mk(1, 9, 0, 0, 0, 0, 4'b1111, 1, 3'b110, 2);  // release, set 9
    vecs[18] = mk(0, 9, 0, 0, 0, 0, 4'b1111, 0, 3'b110, 2);  // idle capture

    rst = 1'b1; rdEn = 0; rdSet = 0; stall = 0;
    updEn = 0; updSet = 0; updWay = 0; wayValid = 4'b1111;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset", 0, 1'b0, 3'b000, 2'd0);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].rdEn, vecs[i].rdSet, vecs[i].stall, vecs[i].updEn,
                    vecs[i].updSet, vecs[i].updWay, vecs[i].wayValid);
      checkOutput("vec", i, vecs[i].expValid, vecs[i].expOut, vecs[i].expVictim);
    end

    // Program every set with a non-D access so all hold nonzero bits.
    for (int s = 0; s < 16; s++) begin
      applyStimulus(0, 0, 0, 1, 4'(s), 2'($urandom_range(0, 2)), 4'b1111);
    end
    applyStimulus(1, 6, 0, 0, 0, 0, 4'b1111);
    checkOutput("preReset", 0, mValid, mOut, refVictim(mOut, 4'b1111));

    // Reset between edges, with an update pending that must be dropped.
    #2;
    updEn = 1; updSet = 4; updWay = 0; rdEn = 1; rdSet = 4;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("asyncReset", 0, 1'b0, 3'b000, 2'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; updEn = 0; rdEn = 0;
    for (int s = 0; s < 16; s++) begin
      applyStimulus(1, 4'(s), 0, 0, 0, 0, 4'b1111);
      checkOutput("postReset", s, 1'b1, 3'b000, 2'd0);
    end

    // Random traffic against the model; set indices restricted sometimes
    // so same-set collisions and forwarding happen often.
    for (int n = 0; n < 400; n++) begin
      bit [3:0] rs, us, wv;
      rs = (n % 3 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      us = ($urandom_range(0, 2) == 0) ? rs : 4'($urandom_range(0, 15));
      wv = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
      applyStimulus(1'($urandom_range(0, 1)), rs, ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), us, 2'($urandom_range(0, 3)), wv);
      checkOutput("rand", n, mValid, mOut, refVictim(mOut, wv));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
